prog_loader: RTL and testbench

- Hardware program/data loader for the 5-stage pipelined CPU. It is the writer side of the instruction/data memory image.
- Accepts a byte stream with a valid/ready handshake, decodes load frames, and issues word writes to Instruction_Memory and byte writes to Data_Memory.
- Raises start_o to launch the CPU once a GO command arrives.
- Replaces simulation-only memory preloading, so that real silicon and FPGA bring-up can boot the core.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_word_assembler.sv | 63 ++++++
 rtl/prog_loader.sv | 218 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program/data loader: command codes,
// FSM state encoding and a small command-classification helper.
package prog_loader_pkg;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'h0F;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_BASE  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // True for the two commands that carry BASE/COUNT/payload bytes.
  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_IMEM) || (b == CMD_DMEM);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian 4-byte word assembler. Bytes arrive LSB first; the
// completed word and a one-cycle word_valid_o pulse are registered and
// appear in the cycle after the 4th byte. word_o holds its last value.
// clr_i drops any partial word (used at the start of every frame).
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [1:0]  byte_cnt_o
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] part_q,  part_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  // Next-state: shift the byte into its lane, complete the word on lane 3.
  always_comb begin
    cnt_d   = cnt_q;
    part_d  = part_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr_i) begin
      cnt_d  = 2'd0;
      part_d = 24'h0;
    end else if (byte_en_i) begin
      case (cnt_q)
        2'd0: part_d[7:0]   = byte_i;
        2'd1: part_d[15:8]  = byte_i;
        2'd2: part_d[23:16] = byte_i;
        default: begin
          word_d  = {byte_i, part_q};
          valid_d = 1'b1;
        end
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  // State registers; async reset discards any partial word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= 2'd0;
      part_q  <= 24'h0;
      word_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Program/data loader: decodes a framed byte stream into word writes to
// instruction memory and byte writes to data memory, then raises start_o
// on GO. Optional trailing per-frame checksum: PROG_LOADER_CHECKSUM_EN.
//
// Handshake: a byte transfers on a rising clk_i edge where valid_i && ready_o.
// ready_o depends only on the FSM state (never on valid_i); the producer
// may hold valid_i low at any point and the loader simply waits.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_BYTES = 32,
  parameter int IA_W       = 8,
  parameter int DA_W       = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      byte_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            imem_we_o,
  output logic [IA_W-1:0] imem_addr_o,
  output logic [31:0]     imem_data_o,
  output logic            dmem_we_o,
  output logic [DA_W-1:0] dmem_addr_o,
  output logic [7:0]      dmem_data_o,
  output logic            start_o,
  output logic            busy_o,
  output logic            err_o,
  output state_e          dbg_state_o
);

  // Address wrap masks (depths are powers of two, so modulo == mask).
  localparam logic [IA_W-1:0] IA_MASK = IA_W'(IMEM_DEPTH - 1);
  localparam logic [DA_W-1:0] DA_MASK = DA_W'(DMEM_BYTES - 1);

  // With checksums, a frame ends on its checksum byte (still in DATA).
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e LAST_NEXT = ST_DATA;
`else
  localparam state_e LAST_NEXT = ST_CMD;
`endif

  state_e          state_q,     state_d;
  logic            is_imem_q,   is_imem_d;
  logic [7:0]      base_q,      base_d;
  logic [7:0]      cnt_q,       cnt_d;
  logic [7:0]      idx_q,       idx_d;
  logic [IA_W-1:0] imem_addr_q, imem_addr_d;
  logic            dmem_we_q,   dmem_we_d;
  logic [DA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]      dmem_data_q, dmem_data_d;

  logic       accept;
  logic       asm_en;
  logic       asm_clr;
  logic [1:0] asm_cnt;
  logic       last_unit;
  logic       csum_byte;
  logic       csum_ok;

  assign accept = valid_i && ready_o;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q,       csum_d;
  logic       csum_phase_q, csum_phase_d;

  assign csum_byte = csum_phase_q;
  assign csum_ok   = (byte_i == csum_q);

  // Running payload sum and "next DATA byte is the checksum" flag.
  always_comb begin
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
    if (accept && state_q == ST_COUNT) begin
      csum_d       = 8'h00;
      csum_phase_d = (byte_i == 8'h00);
    end else if (accept && state_q == ST_DATA) begin
      if (csum_phase_q) begin
        csum_phase_d = 1'b0;
      end else begin
        csum_d = csum_q + byte_i;
        if (last_unit) csum_phase_d = 1'b1;
      end
    end
  end

  // Checksum registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csum_q       <= 8'h00;
      csum_phase_q <= 1'b0;
    end else begin
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
    end
  end
`else
  assign csum_byte = 1'b0;
  assign csum_ok   = 1'b0;
`endif

  // FSM next-state, frame counters and registered write ports.
  always_comb begin
    state_d     = state_q;
    is_imem_d   = is_imem_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    imem_addr_d = imem_addr_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_data_d = dmem_data_q;
    asm_en      = 1'b0;
    asm_clr     = 1'b0;
    last_unit   = 1'b0;
    case (state_q)
      ST_CMD: begin
        if (accept) begin
          asm_clr   = 1'b1;
          is_imem_d = (byte_i == CMD_IMEM);
          if (is_load_cmd(byte_i))   state_d = ST_BASE;
          else if (byte_i == CMD_GO) state_d = ST_DONE;
          else                       state_d = ST_ERR;
        end
      end
      ST_BASE: begin
        if (accept) begin
          base_d  = byte_i;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (accept) begin
          cnt_d   = byte_i;
          idx_d   = 8'h00;
          state_d = (byte_i == 8'h00) ? LAST_NEXT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (csum_byte) begin
            state_d = csum_ok ? ST_CMD : ST_ERR;
          end else if (is_imem_q) begin
            // A word completes when the assembler sees its 4th byte.
            asm_en = 1'b1;
            if (asm_cnt == 2'd3) begin
              imem_addr_d = (base_q[IA_W-1:0] + idx_q[IA_W-1:0]) & IA_MASK;
              idx_d       = idx_q + 8'd1;
              cnt_d       = cnt_q - 8'd1;
              last_unit   = (cnt_q == 8'd1);
            end
          end else begin
            dmem_we_d   = 1'b1;
            dmem_addr_d = (base_q[DA_W-1:0] + idx_q[DA_W-1:0]) & DA_MASK;
            dmem_data_d = byte_i;
            idx_d       = idx_q + 8'd1;
            cnt_d       = cnt_q - 8'd1;
            last_unit   = (cnt_q == 8'd1);
          end
          if (last_unit) state_d = LAST_NEXT;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_CMD;
      is_imem_q   <= 1'b0;
      base_q      <= 8'h00;
      cnt_q       <= 8'h00;
      idx_q       <= 8'h00;
      imem_addr_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      is_imem_q   <= is_imem_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      imem_addr_q <= imem_addr_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_data_q <= dmem_data_d;
    end
  end

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (asm_clr),
    .byte_en_i    (asm_en),
    .byte_i       (byte_i),
    .word_o       (imem_data_o),
    .word_valid_o (imem_we_o),
    .byte_cnt_o   (asm_cnt)
  );

  assign ready_o     = (state_q == ST_CMD) || (state_q == ST_BASE) ||
                       (state_q == ST_COUNT) || (state_q == ST_DATA);
  assign busy_o      = (state_q == ST_BASE) || (state_q == ST_COUNT) ||
                       (state_q == ST_DATA);
  assign start_o     = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);
  assign imem_addr_o = imem_addr_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Build with +define+PROG_LOADER_CHECKSUM_EN
// to exercise the trailing checksum byte.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        valid_i;
  logic        ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [4:0]  dmem_addr_o;
  logic [7:0]  dmem_data_o;
  logic        start_o;
  logic        busy_o;
  logic        err_o;
  state_e      dbg_state_o;

  int total = 0;
  int bad   = 0;

  logic [39:0] imem_exp_q[$];
  logic [15:0] dmem_exp_q[$];
  logic [39:0] imem_got[$];
  logic [15:0] dmem_got[$];
  logic [7:0]  pl_q[$];

  prog_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .byte_i(byte_i), .valid_i(valid_i),
    .ready_o(ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_data_o(dmem_data_o), .start_o(start_o), .busy_o(busy_o),
    .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) imem_got.push_back({imem_addr_o, imem_data_o});
    if (dmem_we_o === 1'b1) dmem_got.push_back({3'b000, dmem_addr_o, dmem_data_o});
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    byte_i  = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Sends a load frame with payload pl_q, appending the checksum when enabled.
  task automatic send_load(input logic [7:0] cmd, input logic [7:0] base, input logic [7:0] count);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(cmd);
    send_byte(base);
    send_byte(count);
    foreach (pl_q[i]) begin
      send_byte(pl_q[i]);
      sum = sum + pl_q[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum);
`endif
    pl_q.delete();
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rst_i   = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    idle(1);
    imem_got.delete();
    dmem_got.delete();
    imem_exp_q.delete();
    dmem_exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b0; valid_i = 1'b0; byte_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if ({imem_we_o, dmem_we_o, start_o, busy_o, err_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {imem_we_o, dmem_we_o, start_o, busy_o, err_o}); end
    total++; if ({imem_addr_o, imem_data_o, dmem_addr_o, dmem_data_o} !== 53'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h exp=0", {imem_addr_o, imem_data_o, dmem_addr_o, dmem_data_o}); end
    total++; if (dbg_state_o !== ST_CMD) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, ST_CMD); end
    rst_i = 1'b1;
    idle(2);
    total++; if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle ready=%b busy=%b exp ready=1 busy=0", ready_o, busy_o); end
  endtask

  task automatic test_imem_frame();
    imem_exp_q = '{40'h00_00500513, 40'h01_000002B3};
    send_byte(8'h01);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL imem_busy got=%b exp=1", busy_o); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50);
    total++; if (imem_we_o !== 1'b0) begin bad++; $display("FAIL imem_early_we got=%b exp=0", imem_we_o); end
    send_byte(8'h00);
    total++; if (imem_we_o !== 1'b1) begin bad++; $display("FAIL imem_we_latency got=%b exp=1", imem_we_o); end
    idle(1);
    total++; if (imem_we_o !== 1'b0) begin bad++; $display("FAIL imem_we_width got=%b exp=0", imem_we_o); end
    send_byte(8'hB3); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h1D);
`endif
    idle(2);
    total++; if (busy_o !== 1'b0 || dbg_state_o !== ST_CMD) begin
      bad++; $display("FAIL imem_end busy=%b state=%0d exp busy=0 state=0", busy_o, dbg_state_o); end
    total++; if (imem_got.size() != imem_exp_q.size() || dmem_got.size() != 0) begin
      bad++; $display("FAIL imem_count got=%0d/%0d exp=%0d/0", imem_got.size(), dmem_got.size(), imem_exp_q.size()); end
    else foreach (imem_exp_q[i]) begin
      total++; if (imem_got[i] !== imem_exp_q[i]) begin
        bad++; $display("FAIL imem_write%0d got=%h exp=%h", i, imem_got[i], imem_exp_q[i]); end
    end
    total++; if (imem_data_o !== 32'h000002B3 || imem_addr_o !== 8'h01) begin
      bad++; $display("FAIL imem_hold got=%h/%h exp=01/000002b3", imem_addr_o, imem_data_o); end
  endtask

  task automatic test_dmem_wrap();
    imem_got.delete(); dmem_got.delete();
    dmem_exp_q = '{16'h1F_AA, 16'h00_BB};
    pl_q = '{8'hAA, 8'hBB};
    send_load(8'h02, 8'h1F, 8'h02);
    idle(2);
    total++; if (dmem_got.size() != dmem_exp_q.size() || imem_got.size() != 0) begin
      bad++; $display("FAIL dmem_count got=%0d/%0d exp=%0d/0", dmem_got.size(), imem_got.size(), dmem_exp_q.size()); end
    else foreach (dmem_exp_q[i]) begin
      total++; if (dmem_got[i] !== dmem_exp_q[i]) begin
        bad++; $display("FAIL dmem_write%0d got=%h exp=%h", i, dmem_got[i], dmem_exp_q[i]); end
    end
    total++; if (dmem_we_o !== 1'b0 || dmem_addr_o !== 5'h00 || dmem_data_o !== 8'hBB) begin
      bad++; $display("FAIL dmem_hold we=%b addr=%h data=%h exp we=0 addr=00 data=bb", dmem_we_o, dmem_addr_o, dmem_data_o); end
  endtask

  task automatic test_back_to_back();
    imem_got.delete(); dmem_got.delete();
    dmem_exp_q = '{16'h03_5A, 16'h1E_C3};
    imem_exp_q = '{40'hFF_12345678, 40'h00_DEADBEEF};
    pl_q = '{8'h5A};
    send_load(8'h02, 8'h03, 8'h01);
    pl_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_load(8'h01, 8'hFF, 8'h02);
    send_load(8'h01, 8'h10, 8'h00);
    pl_q = '{8'hC3};
    send_load(8'h02, 8'h1E, 8'h01);
    idle(2);
    total++; if (imem_got.size() != 2 || dmem_got.size() != 2) begin
      bad++; $display("FAIL b2b_count got=%0d/%0d exp=2/2", imem_got.size(), dmem_got.size()); end
    else begin
      foreach (imem_exp_q[i]) begin
        total++; if (imem_got[i] !== imem_exp_q[i]) begin
          bad++; $display("FAIL b2b_imem%0d got=%h exp=%h", i, imem_got[i], imem_exp_q[i]); end
      end
      foreach (dmem_exp_q[i]) begin
        total++; if (dmem_got[i] !== dmem_exp_q[i]) begin
          bad++; $display("FAIL b2b_dmem%0d got=%h exp=%h", i, dmem_got[i], dmem_exp_q[i]); end
      end
    end
    total++; if (dbg_state_o !== ST_CMD || err_o !== 1'b0) begin
      bad++; $display("FAIL b2b_end state=%0d err=%b exp state=0 err=0", dbg_state_o, err_o); end
  endtask

  task automatic test_go();
    imem_got.delete(); dmem_got.delete();
    pl_q = '{8'h77};
    send_load(8'h02, 8'h08, 8'h01);
    send_byte(8'h0F);
    total++; if (start_o !== 1'b1 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL go start=%b ready=%b busy=%b exp 1/0/0", start_o, ready_o, busy_o); end
    dmem_got.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h99);
    idle(3);
    total++; if (imem_got.size() != 0 || dmem_got.size() != 0 || start_o !== 1'b1) begin
      bad++; $display("FAIL go_hold writes=%0d/%0d start=%b exp 0/0/1", imem_got.size(), dmem_got.size(), start_o); end
    do_reset();
    total++; if (start_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL go_reset start=%b ready=%b exp 0/1", start_o, ready_o); end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h55);
    total++; if (err_o !== 1'b1 || ready_o !== 1'b0 || start_o !== 1'b0) begin
      bad++; $display("FAIL bad_cmd err=%b ready=%b start=%b exp 1/0/0", err_o, ready_o, start_o); end
    send_byte(8'h0F);
    idle(2);
    total++; if (imem_got.size() != 0 || dmem_got.size() != 0 || start_o !== 1'b0) begin
      bad++; $display("FAIL bad_cmd_quiet writes=%0d/%0d start=%b exp 0/0/0", imem_got.size(), dmem_got.size(), start_o); end
    do_reset();
    total++; if (err_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL bad_cmd_reset err=%b ready=%b exp 0/1", err_o, ready_o); end
  endtask

  task automatic test_stall_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    idle(10);
    total++; if (imem_got.size() != 0 || busy_o !== 1'b1 || dbg_state_o !== ST_DATA) begin
      bad++; $display("FAIL stall writes=%0d busy=%b state=%0d exp 0/1/3", imem_got.size(), busy_o, dbg_state_o); end
    rst_i = 1'b0;
    #2;
    total++; if (busy_o !== 1'b0 || imem_we_o !== 1'b0) begin
      bad++; $display("FAIL async_reset busy=%b we=%b exp 0/0", busy_o, imem_we_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle(3);
    total++; if (imem_got.size() != 0) begin bad++; $display("FAIL stall_reset_writes got=%0d exp=0", imem_got.size()); end
    pl_q = '{8'h44, 8'h33, 8'h22, 8'h11};
    send_load(8'h01, 8'h00, 8'h01);
    idle(2);
    total++; if (imem_got.size() != 1) begin bad++; $display("FAIL stall_frame_count got=%0d exp=1", imem_got.size()); end
    else begin
      total++; if (imem_got[0] !== 40'h00_11223344) begin
        bad++; $display("FAIL stall_frame_word got=%h exp=0011223344", imem_got[0]); end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    imem_got.delete(); dmem_got.delete();
    dmem_exp_q = '{16'h04_10, 16'h05_20};
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    idle(2);
    total++; if (dbg_state_o !== ST_CMD || err_o !== 1'b0 || dmem_got.size() != 2) begin
      bad++; $display("FAIL csum_ok state=%0d err=%b writes=%0d exp 0/0/2", dbg_state_o, err_o, dmem_got.size()); end
    else foreach (dmem_exp_q[i]) begin
      total++; if (dmem_got[i] !== dmem_exp_q[i]) begin
        bad++; $display("FAIL csum_write%0d got=%h exp=%h", i, dmem_got[i], dmem_exp_q[i]); end
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    total++; if (dbg_state_o !== ST_CMD || err_o !== 1'b0) begin
      bad++; $display("FAIL csum_zero state=%0d err=%b exp 0/0", dbg_state_o, err_o); end
    dmem_got.delete();
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    idle(2);
    total++; if (err_o !== 1'b1 || ready_o !== 1'b0 || dmem_got.size() != 2) begin
      bad++; $display("FAIL csum_bad err=%b ready=%b writes=%0d exp 1/0/2", err_o, ready_o, dmem_got.size()); end
    do_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL csum_zero_bad err=%b exp=1", err_o); end
    do_reset();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_imem_frame();
    test_dmem_wrap();
    test_back_to_back();
    test_go();
    test_bad_cmd();
    test_stall_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
